// File: rtl/seq_ctrl_pkg.sv
// Shared constants for the sequence-attempt scheduler: FSM state encoding
// and default parameter values.
package seq_ctrl_pkg;

    // FSM state encoding, exposed on the fsm_state debug output.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SHIFT   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_RESP    = 3'd3;
    localparam logic [2:0] ST_LOCKOUT = 3'd4;

    // Default parameter values.
    localparam int DEF_CODE_W   = 24;
    localparam int DEF_OBS_CYC  = 2;
    localparam int DEF_MAX_FAIL = 3;
    localparam int DEF_LOCK_CYC = 64;

endpackage

// File: rtl/seq_rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational from req;
// the "last granted" pointer only moves when the owner strobes advance.
module seq_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 1 means requester 1 was granted last, so requester 0 wins a tie.
    logic last;

    // Tie-break on simultaneous requests in favour of the one not served last.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

    // Remember who was granted; reset gives requester 0 priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (advance) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/seq_attempt_scheduler.sv
// Schedules code-entry attempts from two requesters onto a shared serial
// sequence detector: shifts the code MSB-first, observes det_out for a
// bounded window, reports pass/fail and locks out after repeated failures.
//
// Handshake: a requester raises req[i] and holds code<i> stable; the block
// answers with exactly one ack[i] pulse (pass valid in the same cycle) per
// grant, even if req[i] is dropped early. Every state is time-bounded.
module seq_attempt_scheduler
    import seq_ctrl_pkg::*;
#(
    parameter int CODE_W   = DEF_CODE_W,
    parameter int OBS_CYC  = DEF_OBS_CYC,
    parameter int MAX_FAIL = DEF_MAX_FAIL,
    parameter int LOCK_CYC = DEF_LOCK_CYC
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic [1:0]        req,
    input  logic [CODE_W-1:0] code0,
    input  logic [CODE_W-1:0] code1,
    input  logic              det_out,
    output logic              det_in,
    output logic              det_rst_n,
    output logic [1:0]        gnt,
    output logic [1:0]        ack,
    output logic              pass,
    output logic              busy,
    output logic              locked,
    output logic [1:0]        fail_cnt,
    output logic [2:0]        fsm_state
);

    logic [2:0]        state;
    logic [CODE_W-1:0] sh;       // remaining bits, next bit at the MSB
    logic [15:0]       tmr;      // shared down-counter for SHIFT/WAIT/LOCKOUT
    logic [1:0]        arb_gnt;
    logic              arb_adv;
    logic [CODE_W-1:0] code_sel;

    assign fsm_state = state;
    assign arb_adv   = (state == ST_IDLE) && (req != 2'b00);
    assign code_sel  = arb_gnt[1] ? code1 : code0;

    seq_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (RESET),
        .req     (req),
        .advance (arb_adv),
        .grant   (arb_gnt)
    );

    // Main attempt FSM; all outputs are registered.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state     <= ST_IDLE;
            sh        <= '0;
            tmr       <= '0;
            det_in    <= 1'b0;
            det_rst_n <= 1'b0;
            gnt       <= 2'b00;
            ack       <= 2'b00;
            pass      <= 1'b0;
            busy      <= 1'b0;
            locked    <= 1'b0;
            fail_cnt  <= 2'b00;
        end else begin
            ack <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        gnt       <= arb_gnt;
                        det_in    <= code_sel[CODE_W-1];
                        sh        <= code_sel << 1;
                        tmr       <= 16'(CODE_W - 1);
                        det_rst_n <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // det_out is deliberately not looked at while shifting.
                    if (tmr == '0) begin
                        det_in <= 1'b0;
                        tmr    <= 16'(OBS_CYC - 1);
                        state  <= ST_WAIT;
                    end else begin
                        det_in <= sh[CODE_W-1];
                        sh     <= sh << 1;
                        tmr    <= tmr - 16'd1;
                    end
                end
                ST_WAIT: begin
                    if (det_out) begin
                        pass      <= 1'b1;
                        fail_cnt  <= 2'b00;
                        ack       <= gnt;
                        det_rst_n <= 1'b0;
                        state     <= ST_RESP;
                    end else if (tmr == '0) begin
                        // Silent or deadlocked detector counts as a failure.
                        pass      <= 1'b0;
                        if (fail_cnt != 2'(MAX_FAIL)) begin
                            fail_cnt <= fail_cnt + 2'd1;
                        end
                        ack       <= gnt;
                        det_rst_n <= 1'b0;
                        state     <= ST_RESP;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
                ST_RESP: begin
                    gnt  <= 2'b00;
                    busy <= 1'b0;
                    if (fail_cnt == 2'(MAX_FAIL)) begin
                        locked <= 1'b1;
                        tmr    <= 16'(LOCK_CYC - 1);
                        state  <= ST_LOCKOUT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_LOCKOUT: begin
                    if (tmr == '0) begin
                        locked   <= 1'b0;
                        fail_cnt <= 2'b00;
                        state    <= ST_IDLE;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_attempt_scheduler.sv
// Testbench for seq_attempt_scheduler: a behavioural detector that matches
// the accept code, directed attempts, and an ack-driven scoreboard.
module tb_seq_attempt_scheduler;

    localparam int          W      = 11;  // {owner[1:0], pass, fail_cnt[1:0], lat[5:0]}
    localparam logic [23:0] ACCEPT = 24'h3300C0;
    localparam int          LAT_P  = 25;  // gnt first seen at T+1, pass ack at T+26
    localparam int          LAT_F  = 26;  // timeout ack at T+27

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        RESET;
    logic [1:0]  req;
    logic [23:0] code0, code1;
    logic        det_out;
    logic        det_in, det_rst_n, pass, busy, locked;
    logic [1:0]  gnt, ack, fail_cnt;
    logic [2:0]  fsm_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    seq_attempt_scheduler dut (
        .clk       (clk),
        .RESET     (RESET),
        .req       (req),
        .code0     (code0),
        .code1     (code1),
        .det_out   (det_out),
        .det_in    (det_in),
        .det_rst_n (det_rst_n),
        .gnt       (gnt),
        .ack       (ack),
        .pass      (pass),
        .busy      (busy),
        .locked    (locked),
        .fail_cnt  (fail_cnt),
        .fsm_state (fsm_state)
    );

    // Detector model: matches when the last 24 bits shifted in equal ACCEPT.
    logic [23:0] det_sr;
    logic        force_det;
    always @(posedge clk) begin
        if (!det_rst_n) det_sr <= '0;
        else            det_sr <= {det_sr[22:0], det_in};
    end
    assign det_out = (det_rst_n && (det_sr == ACCEPT)) || force_det;

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [1:0] own, input logic p,
                                          input logic [1:0] fc, input int lat);
        return {own, p, fc, 6'(lat)};
    endfunction

    // Monitor: tracks the grant cycle and checks every ack against the queue.
    int         g_cyc = 0;
    logic [1:0] prev_gnt = 2'b00;
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (gnt !== 2'b00 && prev_gnt === 2'b00) g_cyc = cyc;
            prev_gnt = gnt;
            if (!$isunknown(ack) && ack != 2'b00) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack actual=%b required=none", ack);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_owner", 32'(ack), 32'(e[10:9]));
                    chk("ack_gnt_match", 32'(gnt), 32'(e[10:9]));
                    chk("ack_pass", 32'(pass), 32'(e[8]));
                    chk("ack_fail_cnt", 32'(fail_cnt), 32'(e[7:6]));
                    chk("ack_latency", 32'(cyc - g_cyc), 32'(e[5:0]));
                    chk("resp_det_rst_n", 32'(det_rst_n), 32'd0);
                    chk("resp_busy", 32'(busy), 32'd1);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ack(input int who);
        bit got = 0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (ack[who] === 1'b1) got = 1;
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_gnt();
        bit got = 0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (gnt !== 2'b00 && !$isunknown(gnt)) got = 1;
        end
        if (!got) chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset(input int n);
        RESET = 1'b1;
        req   = 2'b00;
        repeat (n) @(negedge clk);
        RESET = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_state"},     32'(fsm_state), 32'd0);
        chk({tag, "_gnt"},       32'(gnt),       32'd0);
        chk({tag, "_ack"},       32'(ack),       32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_locked"},    32'(locked),    32'd0);
        chk({tag, "_fail_cnt"},  32'(fail_cnt),  32'd0);
        chk({tag, "_det_in"},    32'(det_in),    32'd0);
        chk({tag, "_det_rst_n"}, 32'(det_rst_n), 32'd0);
    endtask

    // Watchdog: never let the run hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int  n_lock;
        bit  gnt_in_lock;
        req       = 2'b00;
        code0     = '0;
        code1     = '0;
        force_det = 1'b0;

        // Reset state.
        do_reset(3);
        check_idle_outputs("reset");
        chk("reset_pass", 32'(pass), 32'd0);

        // Fail on requester 1 (all-zero code times out).
        code1 = 24'h000000;
        exp_q.push_back(pack(2'b10, 1'b0, 2'd1, LAT_F));
        req = 2'b10;
        wait_ack(1);
        req = 2'b00;

        // Pass on requester 0 clears the failure count.
        code0 = ACCEPT;
        exp_q.push_back(pack(2'b01, 1'b1, 2'd0, LAT_P));
        req = 2'b01;
        wait_ack(0);
        req = 2'b00;

        // Reset restores requester 0 priority even though it was served last.
        @(negedge clk);
        do_reset(2);
        code0 = ACCEPT;
        code1 = 24'h000000;
        exp_q.push_back(pack(2'b01, 1'b1, 2'd0, LAT_P));
        exp_q.push_back(pack(2'b10, 1'b0, 2'd1, LAT_F));
        exp_q.push_back(pack(2'b01, 1'b1, 2'd0, LAT_P));
        req = 2'b11;
        wait_ack(0);
        wait_ack(1);
        wait_ack(0);
        req = 2'b00;

        // Three consecutive fails trigger lockout.
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            code1 = 24'h000000;
            exp_q.push_back(pack(2'b10, 1'b0, 2'(k), LAT_F));
            req = 2'b10;
            wait_ack(1);
            req = 2'b00;
        end
        n_lock      = 0;
        gnt_in_lock = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (locked !== 1'b1) break;
            n_lock++;
            if (gnt !== 2'b00) gnt_in_lock = 1;
            if (n_lock == 5) begin
                code0 = ACCEPT;
                exp_q.push_back(pack(2'b01, 1'b1, 2'd0, LAT_P));
                req = 2'b01;
            end
        end
        chk("lock_len", 32'(n_lock), 32'd64);
        chk("lock_no_gnt", 32'(gnt_in_lock), 32'd0);
        chk("lock_exit_fail_cnt", 32'(fail_cnt), 32'd0);
        wait_ack(0);
        req = 2'b00;

        // Deadlock-style code never matches; a det_out pulse during SHIFT is ignored.
        @(negedge clk);
        code0 = 24'h3300F0;
        exp_q.push_back(pack(2'b01, 1'b0, 2'd1, LAT_F));
        req = 2'b01;
        wait_gnt();
        force_det = 1'b1;
        repeat (10) @(negedge clk);
        force_det = 1'b0;
        wait_ack(0);
        req = 2'b00;

        // Reset in the middle of SHIFT aborts without ack.
        @(negedge clk);
        code1 = ACCEPT;
        req   = 2'b10;
        wait_gnt();
        repeat (9) @(negedge clk);
        chk("midshift_busy", 32'(busy), 32'd1);
        RESET = 1'b1;
        req   = 2'b00;
        @(negedge clk);
        check_idle_outputs("midshift_reset");
        RESET = 1'b0;
        repeat (40) @(negedge clk);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_attempt_scheduler.md
SEQ_ATTEMPT_SCHEDULER -- requirements
Module: seq_attempt_scheduler

Interface
REQ-001 SHALL have parameter CODE_W, default 24, meaning code bits shifted per attempt.
REQ-002 SHALL have parameter OBS_CYC, default 2, meaning the max cycles to observe det_out after the last bit.
REQ-003 SHALL have parameter MAX_FAIL, default 3, meaning the consecutive failures that trigger lockout.
REQ-004 SHALL have parameter LOCK_CYC, default 64, meaning the lockout duration in cycles.
REQ-005 SHALL have one clock; reset is synchronous and active-high; ports clk and RESET.
REQ-006 Port list (name, direction, width, meaning):
- clk  in  1  clock.
- RESET  in  1  synchronous active-high reset.
- req  in  2  per-requester attempt request; held until ack.
- code0  in  CODE_W  requester 0 code word; stable while req[0].
- code1  in  CODE_W  requester 1 code word; stable while req[1].
- det_out  in  1  detector match output.
- det_in  out  1  serial bit to detector.
- det_rst_n  out  1  detector reset, active-low.
- gnt  out  2  one-hot owner of the current attempt.
- ack  out  2  one-cycle completion pulse per requester.
- pass  out  1  attempt result; valid with ack.
- busy  out  1  attempt in progress.
- locked  out  1  lockout active.
- fail_cnt  out  2  consecutive failure count.

Function
REQ-007 SHALL implement FSM states IDLE, SHIFT, WAIT, RESP, LOCKOUT.
REQ-008 IDLE: when any req bit is set, SHALL grant one requester, latch its code, set gnt, and go to SHIFT on the next cycle.
REQ-009 Arbitration SHALL be round-robin; on simultaneous requests the requester not granted last wins; after reset requester 0 has priority.
REQ-010 SHIFT SHALL last exactly CODE_W cycles, driving det_in MSB-first, one bit per cycle.
REQ-011 det_rst_n SHALL be 1 only in SHIFT and WAIT; it is 0 in all other states, parking the detector at its initial state.
REQ-012 WAIT SHALL last at most OBS_CYC cycles; det_out=1 in any WAIT cycle records pass=1 and exits to RESP the next cycle; timeout records pass=0.
REQ-013 det_out during SHIFT SHALL be ignored.
REQ-014 RESP SHALL last one cycle and assert ack[owner]=1 with pass valid; gnt is cleared at its end.
REQ-015 Latency: grant in cycle T; SHIFT occupies T+1..T+CODE_W; a detector pass seen in the first WAIT cycle gives ack at T+CODE_W+2.
REQ-016 On pass, fail_cnt SHALL clear to 0.
REQ-017 On fail, fail_cnt SHALL increment, saturating at MAX_FAIL.
REQ-018 After RESP: go to LOCKOUT if fail_cnt==MAX_FAIL, else go to IDLE.
REQ-019 LOCKOUT SHALL hold locked=1 for exactly LOCK_CYC cycles with no grants.
REQ-020 On LOCKOUT exit, fail_cnt SHALL clear to 0 and the FSM returns to IDLE; pending requests are then arbitrated normally.
REQ-021 A detector that never asserts det_out, including a detector stuck in its deadlock state, SHALL be treated as a failure; no state of this block may wait forever.
REQ-022 Dropping req before ack is a protocol violation; the attempt SHALL still complete and still pulse ack.
REQ-023 busy SHALL be 1 in SHIFT, WAIT and RESP.

Reset
REQ-024 RESET sampled high SHALL, in the same edge, force IDLE, gnt=0, ack=0, pass=0, busy=0, locked=0, fail_cnt=0, det_in=0, det_rst_n=0, and RR pointer=requester 0.
REQ-025 Reset mid-attempt or mid-lockout SHALL abort without ack.

Structure
REQ-026 The FSM state enum and the default parameter constants SHALL live in package seq_ctrl_pkg.
REQ-027 Round-robin arbitration SHALL be sub-module seq_rr_arb2: inputs req, advance strobe; output one-hot grant.

Verification
REQ-028 Pass scenario: req[0], code0=24'h3300C0 (detector accept sequence) -> ack[0]=1, pass=1 at T+26, fail_cnt=0.
REQ-029 Fail scenario: req[1], code1=24'h000000 -> WAIT times out after 2 cycles; ack[1]=1, pass=0 at T+27; fail_cnt=1.
REQ-030 Contention scenario: req=2'b11 at reset exit -> requester 0 granted first, requester 1 granted the cycle after RESP, then requester 0 again.
REQ-031 Lockout scenario: three consecutive fails -> locked=1 for 64 cycles; a req during lockout gets no gnt; fail_cnt=0 after exit.
REQ-032 Deadlock scenario: code driving S6 then 1 (24'h3300F0...) -> pass=0 via timeout; det_rst_n returns to 0 in RESP.
REQ-033 Reset mid-SHIFT scenario: RESET at bit 10 -> next cycle IDLE, det_rst_n=0, no ack.
